data_or_capture2: RTL and testbench



---
 rtl/data_or_capture2.sv | 130 +++++++++++++
 tb/tb_data_or_capture2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_or_capture2.sv
// data_or_capture2: capture stage behind the 2-bit OR stage (dataOr2).
// Accepts OR results over valid/ready into a first-word-fall-through FIFO.
// It also keeps a saturating count of words offered while the FIFO was full.
// Optional feature macro: DATA_OR_CAPTURE2_ACC_EN builds the sticky OR
// accumulator (accOut/accClear). Without it, accOut reads 2'b00 and
// accClear is ignored.
module data_or_capture2 #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               dataIn,
  input  logic                     inValid,
  output logic                     inReady,
  output logic [1:0]               dataOut,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               accOut,
  input  logic                     accClear,
  output logic [DROP_W-1:0]        dropCnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0]     PTR_ONE    = 1;
  localparam logic [AW:0]       COUNT_ONE  = 1;
  localparam logic [AW:0]       COUNT_FULL = DEPTH;
  localparam logic [DROP_W-1:0] DROP_ONE   = 1;
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  // FIFO status is decoded from the occupancy; there is no other state machine.
  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fifo_state_t;

  fifo_state_t      state;
  logic [1:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Classify the occupancy into empty / partial / full.
  always_comb begin
    state = PARTIAL;
    if (count == '0) begin
      state = EMPTY;
    end else if (count == COUNT_FULL) begin
      state = FULL;
    end
  end

  // Handshake decode. Readiness ignores outReady, so a full FIFO never takes
  // a word in the same cycle it pops one, and reset blocks acceptance at once.
  always_comb begin
    full     = (state == FULL);
    outValid = (state != EMPTY);
    inReady  = !full && !rst;
    push     = inValid && inReady;
    pop      = outValid && outReady;
    drop     = inValid && !inReady && !rst;
    dataOut  = outValid ? mem[rd_ptr] : 2'b00;
  end

  // Storage array: written on accepted pushes only and never reset, since
  // an empty FIFO masks dataOut anyway.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Count offered-but-refused words, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropCnt <= '0;
    end else if (drop && (dropCnt != DROP_MAX)) begin
      dropCnt <= dropCnt + DROP_ONE;
    end
  end

`ifdef DATA_OR_CAPTURE2_ACC_EN
  // Sticky OR of accepted words; a clear that coincides with a push restarts
  // the accumulation from that word rather than losing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      accOut <= 2'b00;
    end else if (accClear && push) begin
      accOut <= dataIn;
    end else if (accClear) begin
      accOut <= 2'b00;
    end else if (push) begin
      accOut <= accOut | dataIn;
    end
  end
`else
  logic unused_acc_clear;

  assign accOut           = 2'b00;
  assign unused_acc_clear = accClear;
`endif

endmodule

// File: tb/tb_data_or_capture2.sv
// tb_data_or_capture2: table-driven vectors plus hand-written sequences,
// with a queue scoreboard checking every popped word and a small model
// of occupancy, accumulator and drop counter.
module tb_data_or_capture2;

  localparam int DEPTH    = 4;
  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;
`ifdef DATA_OR_CAPTURE2_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  dataIn;
  logic        inValid;
  logic        inReady;
  logic [1:0]  dataOut;
  logic        outValid;
  logic        outReady;
  logic [2:0]  count;
  logic [1:0]  accOut;
  logic        accClear;
  logic [7:0]  dropCnt;

  data_or_capture2 #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady),
    .count    (count),
    .accOut   (accOut),
    .accClear (accClear),
    .dropCnt  (dropCnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       iv;
    logic [1:0] d;
    logic       orr;
    logic       clr;
    int         exp_count;
    logic       exp_valid;
    logic [1:0] exp_data;
    int         exp_drop;
  } vec_t;

  vec_t       vecs [14];
  logic [1:0] sb_q [$];
  logic [1:0] m_acc;
  int         m_drop;
  int         n_pass;
  int         n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Compare every observable output against the model after an edge.
  task automatic checkOutput();
    chk("count", 32'(count), 32'(sb_q.size()));
    chk("outValid", 32'(outValid), 32'(sb_q.size() != 0));
    chk("dataOut", 32'(dataOut), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'd0);
    chk("accOut", 32'(accOut), 32'(m_acc));
    chk("dropCnt", 32'(dropCnt), 32'(m_drop));
  endtask

  // Drive one cycle of inputs, check readiness and popped data before the
  // edge, then advance the model and check the registered outputs.
  task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] d,
                               input logic orr, input logic clr);
    logic m_ready;
    logic do_push;
    logic do_pop;
    @(negedge clk);
    rst      = r;
    inValid  = iv;
    dataIn   = d;
    outReady = orr;
    accClear = clr;
    #1;
    m_ready = (sb_q.size() < DEPTH) && !r;
    do_push = iv && m_ready;
    do_pop  = (sb_q.size() != 0) && orr && !r;
    chk("inReady", 32'(inReady), 32'(m_ready));
    if (do_pop) begin
      chk("pop_data", 32'(dataOut), 32'(sb_q[0]));
    end
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      m_acc  = 2'b00;
      m_drop = 0;
    end else begin
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(d);
      if (ACC_EN) begin
        if (clr && do_push) m_acc = d;
        else if (clr) m_acc = 2'b00;
        else if (do_push) m_acc = m_acc | d;
      end
      if (iv && !m_ready && (m_drop < DROP_MAX)) m_drop++;
    end
    #1;
    checkOutput();
  endtask

  // Bound the whole run in case something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    n_pass   = 0;
    n_total  = 0;
    m_acc    = 2'b00;
    m_drop   = 0;
    rst      = 1'b1;
    inValid  = 1'b0;
    dataIn   = 2'b00;
    outReady = 1'b0;
    accClear = 1'b0;

    //        r     iv    d      orr   clr   cnt val   data   drop
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0, 1'b0, 2'b00, 0};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1, 1'b1, 2'b10, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 0, 1'b0, 2'b00, 0};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1, 1'b1, 2'b01, 0};
    vecs[4]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2, 1'b1, 2'b01, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3, 1'b1, 2'b01, 0};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4, 1'b1, 2'b01, 0};
    vecs[7]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4, 1'b1, 2'b01, 1};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4, 1'b1, 2'b01, 2};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4, 1'b1, 2'b01, 3};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 3, 1'b1, 2'b10, 3};
    vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2, 1'b1, 2'b00, 3};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1, 1'b1, 2'b11, 3};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 0, 1'b0, 2'b00, 3};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].orr, vecs[i].clr);
      chk("vec_count", 32'(count), 32'(vecs[i].exp_count));
      chk("vec_valid", 32'(outValid), 32'(vecs[i].exp_valid));
      chk("vec_data", 32'(dataOut), 32'(vecs[i].exp_data));
      chk("vec_drop", 32'(dropCnt), 32'(vecs[i].exp_drop));
      if (i == 1) chk("vec_acc_first", 32'(accOut), ACC_EN ? 32'd2 : 32'd0);
    end

    // Streaming at count=2 across pointer wrap, then full with pop and offer.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      chk("stream_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("full_pop_no_push", 32'(count), 32'd3);

    // Reset mid-stream at count=3 with a word offered.
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(outValid), 32'd0);
    chk("rst_drop", 32'(dropCnt), 32'd0);
    chk("rst_ready", 32'(inReady), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("post_rst_ready", 32'(inReady), 32'd1);

    // Accumulator clear priority.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("acc_push", 32'(accOut), ACC_EN ? 32'd1 : 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 1'b1);
    chk("acc_clr_push", 32'(accOut), ACC_EN ? 32'd2 : 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    chk("acc_clr_alone", 32'(accOut), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, 1'b0);
    chk("acc_or", 32'(accOut), ACC_EN ? 32'd3 : 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);

    // Drop counter saturation.
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'(i), 1'b0, 1'b0);
    for (int i = 0; i < 255; i++) applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("drop_at_max", 32'(dropCnt), 32'd255);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    chk("drop_saturated", 32'(dropCnt), 32'd255);
    chk("drop_count_full", 32'(count), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
